// File: rtl/plru_pkg.sv
// Shared types and tree-PLRU helpers for the per-set PLRU controller.
// Geometry is fixed here; the controller defaults its parameters to it.
package plru_pkg;

  localparam int PLRU_ASSOC = 8;
  localparam int PLRU_SETS  = 64;
  localparam int PLRU_WW    = $clog2(PLRU_ASSOC);
  localparam int PLRU_NB    = PLRU_ASSOC - 1;

  typedef logic [PLRU_WW-1:0] plru_way_t;
  typedef logic [PLRU_NB-1:0] plru_bits_t;

  typedef enum logic [1:0] {
    OP_TOUCH  = 2'b00,
    OP_VICTIM = 2'b01,
    OP_PEEK   = 2'b10,
    OP_CLEAR  = 2'b11
  } plru_op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } plru_state_e;

  function automatic plru_way_t plru_victim(input plru_bits_t bits);
    plru_way_t v;
    plru_way_t a;
    logic      b;
    v = '0;
    a = '0;
    for (int k = 0; k < PLRU_WW; k++) begin
      b = bits[a];
      v = plru_way_t'({v, b});
      a = a + a + plru_way_t'(1) + plru_way_t'(b);
    end
    return v;
  endfunction

  // Each visited node is flipped to point away from the touched way.
  function automatic plru_bits_t plru_touch(input plru_bits_t bits,
                                            input plru_way_t  way);
    plru_bits_t r;
    plru_way_t  w;
    plru_way_t  a;
    logic       b;
    r = bits;
    w = way;
    a = '0;
    for (int k = 0; k < PLRU_WW; k++) begin
      b    = w[PLRU_WW-1];
      w    = w << 1;
      r[a] = ~b;
      a    = a + a + plru_way_t'(1) + plru_way_t'(b);
    end
    return r;
  endfunction

endpackage

// File: rtl/plru_set_controller_if.sv
// Request/response handshake bundle between the cache FSM and the
// PLRU controller; master is the requester, slave the controller.
interface plru_set_controller_if #(
  parameter int SW = 6,
  parameter int WW = 3,
  parameter int NB = 7
);
  import plru_pkg::*;

  logic          req_valid;
  logic          req_ready;
  plru_op_e      req_op;
  logic [SW-1:0] req_set;
  logic [WW-1:0] req_way;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WW-1:0] rsp_way;
  logic [NB-1:0] rsp_bits;
  logic          init_done;

  modport master (
    output req_valid, req_op, req_set, req_way, rsp_ready,
    input  req_ready, rsp_valid, rsp_way, rsp_bits, init_done
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way, rsp_ready,
    output req_ready, rsp_valid, rsp_way, rsp_bits, init_done
  );

endinterface

// File: rtl/plru_lru_ram.sv
// Tree-bit storage: one write port, one registered read port.
// The array has no reset; the controller's INIT sweep clears it.
module plru_lru_ram #(
  parameter int NUM_SETS = 64,
  parameter int WIDTH    = 7,
  parameter int SW       = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [SW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [SW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [NUM_SETS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/plru_set_controller.sv
// Per-set tree-PLRU sequencer: INIT sweep, then one op per 4 cycles.
// Define PLRU_STATS_EN to add saturating touch/victim counters.
module plru_set_controller
  import plru_pkg::*;
#(
  parameter int ASSOC    = PLRU_ASSOC,
  parameter int NUM_SETS = PLRU_SETS
) (
  input  logic         clk,
  input  logic         rst_n,
  plru_set_controller_if.slave bus
`ifdef PLRU_STATS_EN
  ,
  output logic [31:0]  touch_cnt,
  output logic [31:0]  victim_cnt
`endif
);

  localparam int SW = $clog2(NUM_SETS);
  localparam int WW = $clog2(ASSOC);
  localparam int NB = ASSOC - 1;

  plru_state_e   state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  plru_op_e      op_q, op_d;
  logic [SW-1:0] set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  logic [WW-1:0] rsp_way_q, rsp_way_d;
  logic [NB-1:0] rsp_bits_q, rsp_bits_d;
  logic          init_done_q, init_done_d;

  logic          ram_we;
  logic [SW-1:0] ram_waddr;
  logic [NB-1:0] ram_wdata;
  logic [NB-1:0] ram_rdata;
  logic [WW-1:0] vic;

  plru_lru_ram #(
    .NUM_SETS(NUM_SETS),
    .WIDTH   (NB),
    .SW      (SW)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(set_q),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    set_d       = set_q;
    way_d       = way_q;
    rsp_way_d   = rsp_way_q;
    rsp_bits_d  = rsp_bits_q;
    init_done_d = init_done_q;
    ram_we      = 1'b0;
    ram_waddr   = set_q;
    ram_wdata   = '0;
    vic         = plru_victim(ram_rdata);
    unique case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        if (cnt_q == SW'(NUM_SETS - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          set_d   = bus.req_set;
          way_d   = bus.req_way;
          state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_WRITE;
      ST_WRITE: begin
        state_d = ST_RESP;
        unique case (op_q)
          OP_TOUCH: begin
            ram_we     = 1'b1;
            ram_wdata  = plru_touch(ram_rdata, way_q);
            rsp_way_d  = way_q;
            rsp_bits_d = ram_wdata;
          end
          OP_VICTIM: begin
            ram_we     = 1'b1;
            ram_wdata  = plru_touch(ram_rdata, vic);
            rsp_way_d  = vic;
            rsp_bits_d = ram_wdata;
          end
          OP_PEEK: begin
            rsp_way_d  = vic;
            rsp_bits_d = ram_rdata;
          end
          OP_CLEAR: begin
            ram_we     = 1'b1;
            rsp_way_d  = '0;
            rsp_bits_d = '0;
          end
        endcase
      end
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      op_q        <= OP_TOUCH;
      set_q       <= '0;
      way_q       <= '0;
      rsp_way_q   <= '0;
      rsp_bits_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      set_q       <= set_d;
      way_q       <= way_d;
      rsp_way_q   <= rsp_way_d;
      rsp_bits_q  <= rsp_bits_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_way   = rsp_way_q;
  assign bus.rsp_bits  = rsp_bits_q;
  assign bus.init_done = init_done_q;

`ifdef PLRU_STATS_EN
  logic [31:0] touch_cnt_q;
  logic [31:0] victim_cnt_q;
  logic        rsp_hs;

  assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      touch_cnt_q  <= '0;
      victim_cnt_q <= '0;
    end else if (rsp_hs) begin
      if (op_q == OP_TOUCH && touch_cnt_q != '1)
        touch_cnt_q <= touch_cnt_q + 32'd1;
      if (op_q == OP_VICTIM && victim_cnt_q != '1)
        victim_cnt_q <= victim_cnt_q + 32'd1;
    end
  end

  assign touch_cnt  = touch_cnt_q;
  assign victim_cnt = victim_cnt_q;
`endif

endmodule

// File: tb/tb_plru_set_controller.sv
// Directed + random bench for plru_set_controller against a
// node-array tree model built from the walk rules.
module tb_plru_set_controller;
  import plru_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  plru_set_controller_if #(.SW(6), .WW(3), .NB(7)) bus ();

`ifdef PLRU_STATS_EN
  logic [31:0] touch_cnt;
  logic [31:0] victim_cnt;
`endif

  plru_set_controller #(.ASSOC(8), .NUM_SETS(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef PLRU_STATS_EN
    ,
    .touch_cnt (touch_cnt),
    .victim_cnt(victim_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  bit m_tree [64][7];
  int m_touch = 0;
  int m_vict  = 0;
  int r_way;
  int r_bits;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_bits(input int s);
    int r = 0;
    for (int i = 0; i < 7; i++)
      if (m_tree[s][i]) r += (1 << i);
    return r;
  endfunction

  function automatic int m_victim(input int s);
    int a = 0;
    int v = 0;
    int b;
    for (int k = 0; k < 3; k++) begin
      b = int'(m_tree[s][a]);
      v = v * 2 + b;
      a = 2 * a + 1 + b;
    end
    return v;
  endfunction

  function automatic void m_touch_way(input int s, input int w);
    int a = 0;
    int b;
    for (int k = 0; k < 3; k++) begin
      b = (w >> (2 - k)) & 1;
      m_tree[s][a] = (b == 0);
      a = 2 * a + 1 + b;
    end
  endfunction

  function automatic void m_clear_all();
    for (int s = 0; s < 64; s++)
      for (int i = 0; i < 7; i++) m_tree[s][i] = 1'b0;
    m_touch = 0;
    m_vict  = 0;
  endfunction

  function automatic void m_apply(input int op, input int s, input int w,
                                  output int ew, output int eb);
    int v;
    ew = 0;
    case (op)
      0: begin m_touch_way(s, w); ew = w; m_touch++; end
      1: begin
        v = m_victim(s);
        m_touch_way(s, v);
        ew = v;
        m_vict++;
      end
      2: ew = m_victim(s);
      default: for (int i = 0; i < 7; i++) m_tree[s][i] = 1'b0;
    endcase
    eb = m_bits(s);
  endfunction

  task automatic drive_req(input int op, input int s, input int w);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = plru_op_e'(2'(op));
    bus.req_set   = 6'(s);
    bus.req_way   = 3'(w);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rspv"}, int'(bus.rsp_valid), 1);
  endtask

  task automatic do_op(input int op, input int s, input int w,
                       input int hold, input string tag);
    int ew;
    int eb;
    drive_req(op, s, w);
    wait_rsp(tag);
    repeat (hold) @(negedge clk);
    m_apply(op, s, w, ew, eb);
    r_way  = int'(bus.rsp_way);
    r_bits = int'(bus.rsp_bits);
    chk({tag, "_way"}, r_way, ew);
    chk({tag, "_bits"}, r_bits, eb);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_init(input string tag);
    int n = 0;
    int seen = 0;
    while (!bus.req_ready && n < 200) begin
      if (bus.rsp_valid) seen++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, 64);
    chk({tag, "_done"}, int'(bus.init_done), 1);
    chk({tag, "_norsp"}, seen, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_w [3];
    int exp_b [3];
    int ew;
    int eb;
    int seen;
    int op;
    int sel;

    bus.req_valid = 1'b0;
    bus.req_op    = OP_TOUCH;
    bus.req_set   = '0;
    bus.req_way   = '0;
    bus.rsp_ready = 1'b0;
    m_clear_all();

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_rspv", int'(bus.rsp_valid), 0);
    chk("rst_way", int'(bus.rsp_way), 0);
    chk("rst_bits", int'(bus.rsp_bits), 0);
    chk("rst_done", int'(bus.init_done), 0);
    rst_n = 1'b1;
    run_init("init");

    do_op(2, 33, 0, 0, "peek33");
    chk("peek33_zero", r_bits, 0);

    exp_w = '{0, 4, 2};
    exp_b = '{'h0B, 'h2E, 'h3D};
    for (int i = 0; i < 3; i++) begin
      do_op(1, 5, 0, 0, "vic5");
      chk("vic5_way_c", r_way, exp_w[i]);
      chk("vic5_bits_c", r_bits, exp_b[i]);
    end

    do_op(3, 5, 0, 0, "clr5");
    chk("clr5_c", r_bits, 0);
    do_op(0, 5, 7, 0, "t5w7");
    chk("t5w7_c", r_bits, 'h00);
    do_op(0, 5, 0, 1, "t5w0");
    chk("t5w0_c", r_bits, 'h0B);
    do_op(0, 5, 7, 0, "t5w7b");
    chk("t5w7b_c", r_bits, 'h0A);
    do_op(2, 6, 0, 0, "peek6");
    chk("peek6_c", r_bits, 0);

    drive_req(1, 12, 0);
    wait_rsp("stall");
    m_apply(1, 12, 0, ew, eb);
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = i[0];
      bus.req_op    = OP_TOUCH;
      bus.req_set   = 6'd20;
      bus.req_way   = 3'd3;
      @(negedge clk);
      chk("stall_v", int'(bus.rsp_valid), 1);
      chk("stall_way", int'(bus.rsp_way), ew);
      chk("stall_bits", int'(bus.rsp_bits), eb);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    seen = 0;
    repeat (6) begin
      if (bus.rsp_valid) seen++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    chk("no_extra_rsp", seen, 0);
    do_op(2, 20, 0, 0, "peek20");

    do_op(0, 9, 3, 0, "t9w3");
    drive_req(0, 9, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rspv", int'(bus.rsp_valid), 0);
    chk("mid_rst_ready", int'(bus.req_ready), 0);
    chk("mid_rst_done", int'(bus.init_done), 0);
    m_clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init("reinit");
    do_op(2, 9, 0, 0, "peek9");
    chk("peek9_c", r_bits, 0);
`ifdef PLRU_STATS_EN
    chk("stats_rst_t", int'(touch_cnt), 0);
    chk("stats_rst_v", int'(victim_cnt), 0);
`endif

    for (int i = 0; i < 5000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) op = 0;
      else if (sel < 7) op = 1;
      else if (sel < 9) op = 2;
      else op = 3;
      do_op(op,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                        : $urandom_range(0, 7),
            $urandom_range(0, 7),
            $urandom_range(0, 2), "rnd");
    end

`ifdef PLRU_STATS_EN
    chk("stats_touch", int'(touch_cnt), m_touch);
    chk("stats_victim", int'(victim_cnt), m_vict);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
